segment_sequencer: RTL and testbench
====================================

Name: segment_sequencer

Overview:
- Control side of the record FIFO in the BeagleG FPGA motion backend.
- Pulls 16-byte motion-segment records from the FIFO over its available/request/ready handshake and executes each one.
- Each segment is a loop count, a tick period and per-axis DDA increments; the block produces step/dir signals for up to AXES stepper axes.
- Sits between the record FIFO and the motor-driver pins; it is the only consumer of the FIFO.

Parameters:
- RECORD_SIZE_BYTES, 16, record width in bytes; the layout below requires exactly 16.
- AXES, 4, number of step/dir axes (1..4).
- STEP_PULSE_CLKS, 4, step pulse high time in clk cycles (>=1).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-low reset.
- enable, input, 1, permits fetching new segments.
- abort, input, 1, synchronous stop; high for 1 cycle is sufficient.
- fifo_available, input, 1, FIFO holds at least one record.
- fifo_request, output, 1, one-cycle pull request to the FIFO.
- fifo_record_ready, input, 1, fifo_record is valid in this cycle.
- fifo_record, input, RECORD_SIZE_BYTES*8, record data.
- step, output, AXES, step pulses.
- dir, output, AXES, direction levels.
- busy, output, 1, state is not IDLE.
- segments_done, output, 16, completed-segment count; wraps at 16 bits.

Behaviour:
- Record layout:
  - [127:96] loops (u32).
  - [95:80] period (u16, clocks per loop).
  - [67:64] dir bits.
  - [16*a+15:16*a] increment for axis a.
  - Other bits are ignored.
- Reset (rst low, async): all outputs 0, state IDLE, accumulators 0, counters 0.
- IDLE:
  - If enable && fifo_available in cycle N, fifo_request is high in cycle N+1 only; state -> FETCH.
  - fifo_request is never asserted outside this transition. At most one request is outstanding.
- FETCH: wait for fifo_record_ready with no timeout. On ready, latch loops, period and increments; drive dir from the record.
  - Effective period is max(period, 2*STEP_PULSE_CLKS). Period 0 is therefore clamped too.
  - loops==0: segment is skipped; segments_done increments; state -> IDLE.
  - Otherwise: load the period counter; state -> RUN.
- RUN:
  - The period counter decrements every cycle. When it reaches 0 it generates a tick, reloads, and loops decrements.
  - On a tick, every axis computes {carry, acc} = acc + inc as a 17-bit sum.
  - carry=1 raises step[a] for exactly STEP_PULSE_CLKS cycles, starting in the cycle after the tick.
  - The first tick occurs eff_period cycles after the load.
- Segment end:
  - After the tick that brings loops to 0, the block waits until all step pulses are low.
  - It then increments segments_done and goes to IDLE. Fetching the next record resumes per the IDLE rule.
  - dir never changes while any step is high.
- Accumulators persist across segments so fractional steps carry over. They are cleared only by reset or abort.
- enable low: the current segment runs to completion; no new fetch is issued.
- abort:
  - In IDLE or RUN: next cycle state -> IDLE; step and accumulators are cleared; dir is held; segments_done is unchanged.
  - In FETCH: state -> DISCARD. Wait for fifo_record_ready, drop the record, then go to IDLE. This keeps the FIFO handshake consistent.
  - A second abort while in DISCARD has no further effect.
- busy = (state != IDLE).
- States: IDLE, FETCH, RUN, DISCARD.

Decomposition:
- Package beagleg_pkg holds:
  - Field offset/width constants for the record layout.
  - segment_t packed struct: loops, period, dir, inc[4].
  - seq_state_t enum.
  - MAX_AXES = 4.
- Sub-module step_axis, instantiated once per axis: 16-bit accumulator, carry detect, pulse-stretch counter. Its inputs are tick, inc and clear; its output is step.

Test Plan:
- Record loops=4, period=10, inc0=0x8000, others 0, dir=0b0001 -> dir[0]=1 at latch; exactly 2 step[0] pulses starting 21 and 41 cycles after the latch; each pulse is 4 cycles wide; segments_done=1; busy falls after the pulses end.
- Record loops=3, period=8, inc1=0xFFFF -> ticks 1..3 give acc 0xFFFF, 0xFFFE, 0xFFFD; carry on ticks 2 and 3 only; 2 pulses on step[1].
- Record period=0 or period=3 with STEP_PULSE_CLKS=4 -> ticks every 8 cycles; pulses never overlap; step stays low for 4 cycles between consecutive pulses.
- Record loops=0 -> consumed with no step activity; segments_done increments; the next record is fetched if available.
- Abort during FETCH, ready arrives 5 cycles later -> record is discarded, no step or dir change, returns to IDLE, exactly one fifo_request total.
- Async reset mid-pulse, and enable held low with fifo_available=1 -> step/dir/busy are 0 immediately on reset; fifo_request is never asserted while enable is low.

Source files
------------

// File: rtl/beagleg_pkg.sv
// beagleg_pkg: shared types and record layout for the BeagleG motion backend.
//   - Field offsets/widths of the 16-byte motion-segment record.
//   - segment_t: unpacked view of one record (loops, period, dir, inc[4]).
//   - seq_state_t: segment sequencer states.
//   - unpack_record / clamp_period helpers.
package beagleg_pkg;

  localparam int MAX_AXES    = 4;
  localparam int RECORD_BITS = 128;

  localparam int LOOPS_LSB  = 96;
  localparam int LOOPS_W    = 32;
  localparam int PERIOD_LSB = 80;
  localparam int PERIOD_W   = 16;
  localparam int DIR_LSB    = 64;
  localparam int DIR_W      = 4;
  localparam int INC_W      = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    RUN     = 2'd2,
    DISCARD = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic [LOOPS_W-1:0]                loops;
    logic [PERIOD_W-1:0]               period;
    logic [DIR_W-1:0]                  dir;
    logic [MAX_AXES-1:0][INC_W-1:0]    inc;
  } segment_t;

  // Split a raw record into its fields; bits [79:68] carry nothing.
  function automatic segment_t unpack_record(input logic [RECORD_BITS-1:0] rec);
    segment_t seg;
    seg.loops  = rec[LOOPS_LSB +: LOOPS_W];
    seg.period = rec[PERIOD_LSB +: PERIOD_W];
    seg.dir    = rec[DIR_LSB +: DIR_W];
    for (int a = 0; a < MAX_AXES; a++) begin
      seg.inc[a] = rec[INC_W*a +: INC_W];
    end
    return seg;
  endfunction

  // A tick must leave room for a full pulse plus an equally long gap.
  function automatic logic [PERIOD_W-1:0] clamp_period(input logic [PERIOD_W-1:0] period,
                                                       input logic [PERIOD_W-1:0] min_period);
    logic [PERIOD_W-1:0] eff;
    if (period < min_period) begin
      eff = min_period;
    end else begin
      eff = period;
    end
    return eff;
  endfunction

endpackage

// File: rtl/segment_sequencer_step_axis.sv
// step_axis: one DDA axis of the segment sequencer.
//   clk, rst   : clock, asynchronous active-low reset
//   tick       : add inc into the accumulator this cycle
//   clear      : synchronous clear of accumulator and pulse (abort)
//   inc [16]   : per-tick increment
//   step       : pulse, high STEP_PULSE_CLKS cycles starting after a carry tick
module step_axis
  import beagleg_pkg::*;
#(
  parameter int STEP_PULSE_CLKS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             clear,
  input  logic [INC_W-1:0] inc,
  output logic             step
);

  localparam int PW = $clog2(STEP_PULSE_CLKS + 1);
  localparam logic [PW-1:0] PULSE_LEN = PW'(STEP_PULSE_CLKS);

  logic [INC_W-1:0] acc_r;
  logic [PW-1:0]    pulse_cnt_r;
  logic             step_r;
  logic [INC_W:0]   sum_s;

  // The 17th bit of the sum is the carry that emits a step.
  assign sum_s = {1'b0, acc_r} + {1'b0, inc};

  // Accumulator and pulse stretcher; clear wins over a tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r       <= {INC_W{1'b0}};
      pulse_cnt_r <= {PW{1'b0}};
      step_r      <= 1'b0;
    end else if (clear) begin
      acc_r       <= {INC_W{1'b0}};
      pulse_cnt_r <= {PW{1'b0}};
      step_r      <= 1'b0;
    end else begin
      if (tick) begin
        acc_r <= sum_s[INC_W-1:0];
      end
      if (tick && sum_s[INC_W]) begin
        pulse_cnt_r <= PULSE_LEN;
        step_r      <= 1'b1;
      end else if (pulse_cnt_r != {PW{1'b0}}) begin
        pulse_cnt_r <= pulse_cnt_r - PW'(1);
        step_r      <= (pulse_cnt_r > PW'(1));
      end
    end
  end

  assign step = step_r;

endmodule

// File: rtl/segment_sequencer.sv
// segment_sequencer: pulls motion-segment records from the record FIFO and
// turns them into step/dir signals.
//   clk, rst            : clock, asynchronous active-low reset
//   enable              : allow fetching new segments
//   abort               : synchronous stop (one cycle suffices)
//   fifo_available      : FIFO holds at least one record
//   fifo_request        : one-cycle pull request to the FIFO
//   fifo_record_ready   : fifo_record valid this cycle
//   fifo_record         : loops[127:96] period[95:80] dir[67:64] inc[a]=[16a+15:16a]
//   step, dir [AXES]    : stepper pulses and direction levels
//   busy                : sequencer not idle
//   segments_done [16]  : completed-segment count, wrapping
module segment_sequencer
  import beagleg_pkg::*;
#(
  parameter int RECORD_SIZE_BYTES = 16,
  parameter int AXES              = 4,
  parameter int STEP_PULSE_CLKS   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           abort,
  input  logic                           fifo_available,
  output logic                           fifo_request,
  input  logic                           fifo_record_ready,
  input  logic [RECORD_SIZE_BYTES*8-1:0] fifo_record,
  output logic [AXES-1:0]                step,
  output logic [AXES-1:0]                dir,
  output logic                           busy,
  output logic [15:0]                    segments_done
);

  localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(2 * STEP_PULSE_CLKS);

  seq_state_t                     state_r, state_next_s;
  segment_t                       seg_s;
  logic [PERIOD_W-1:0]            eff_period_s;
  logic [LOOPS_W-1:0]             loops_r;
  logic [PERIOD_W-1:0]            period_r;
  logic [PERIOD_W-1:0]            cnt_r;
  logic [MAX_AXES-1:0][INC_W-1:0] inc_r;
  logic [AXES-1:0]                dir_r;
  logic [AXES-1:0]                step_s;
  logic                           fifo_request_r;
  logic                           busy_r;
  logic [15:0]                    segments_done_r;
  logic                           request_s, latch_s, count_s, tick_s, clear_s, done_s;
  logic                           unused_record;

  assign seg_s         = unpack_record(fifo_record[RECORD_BITS-1:0]);
  assign eff_period_s  = clamp_period(seg_s.period, MIN_PERIOD);
  assign unused_record = ^fifo_record;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_next_s = state_r;
    request_s    = 1'b0;
    latch_s      = 1'b0;
    count_s      = 1'b0;
    tick_s       = 1'b0;
    clear_s      = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (abort) begin
          clear_s = 1'b1;
        end else if (enable && fifo_available) begin
          request_s    = 1'b1;
          state_next_s = FETCH;
        end else begin
          state_next_s = IDLE;
        end
      end
      FETCH: begin
        if (abort) begin
          // A record already on the bus is consumed here, otherwise drained later.
          clear_s = 1'b1;
          if (fifo_record_ready) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = DISCARD;
          end
        end else if (fifo_record_ready) begin
          latch_s = 1'b1;
          if (seg_s.loops == 32'd0) begin
            done_s       = 1'b1;
            state_next_s = IDLE;
          end else begin
            state_next_s = RUN;
          end
        end else begin
          state_next_s = FETCH;
        end
      end
      RUN: begin
        if (abort) begin
          clear_s      = 1'b1;
          state_next_s = IDLE;
        end else if (loops_r != 32'd0) begin
          count_s = 1'b1;
          if (cnt_r == 16'd1) begin
            tick_s = 1'b1;
          end else begin
            tick_s = 1'b0;
          end
        end else if (step_s == {AXES{1'b0}}) begin
          // Last tick done; finish only once every pulse has ended.
          done_s       = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = RUN;
        end
      end
      DISCARD: begin
        if (fifo_record_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DISCARD;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Segment registers: latch on fetch, then period and loop counting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      loops_r  <= 32'd0;
      period_r <= 16'd0;
      cnt_r    <= 16'd0;
      inc_r    <= {(MAX_AXES*INC_W){1'b0}};
      dir_r    <= {AXES{1'b0}};
    end else if (latch_s) begin
      loops_r  <= seg_s.loops;
      period_r <= eff_period_s;
      cnt_r    <= eff_period_s;
      inc_r    <= seg_s.inc;
      dir_r    <= seg_s.dir[AXES-1:0];
    end else if (count_s) begin
      if (tick_s) begin
        cnt_r   <= period_r;
        loops_r <= loops_r - 32'd1;
      end else begin
        cnt_r <= cnt_r - 16'd1;
      end
    end
  end

  // Registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_request_r  <= 1'b0;
      busy_r          <= 1'b0;
      segments_done_r <= 16'd0;
    end else begin
      fifo_request_r <= request_s;
      busy_r         <= (state_next_s != IDLE);
      if (done_s) begin
        segments_done_r <= segments_done_r + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < AXES; g++) begin : g_axis
    step_axis #(
      .STEP_PULSE_CLKS(STEP_PULSE_CLKS)
    ) u_axis (
      .clk  (clk),
      .rst  (rst),
      .tick (tick_s),
      .clear(clear_s),
      .inc  (inc_r[g]),
      .step (step_s[g])
    );
  end

  assign fifo_request  = fifo_request_r;
  assign step          = step_s;
  assign dir           = dir_r;
  assign busy          = busy_r;
  assign segments_done = segments_done_r;

endmodule

// File: tb/tb_segment_sequencer.sv
module tb_segment_sequencer;

  localparam int AXES = 4;
  localparam int SPC  = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           enable;
  logic           abort;
  logic           fifo_available;
  logic           fifo_request;
  logic           fifo_record_ready;
  logic [127:0]   fifo_record;
  logic [AXES-1:0] step;
  logic [AXES-1:0] dir;
  logic           busy;
  logic [15:0]    segments_done;

  segment_sequencer #(
    .RECORD_SIZE_BYTES(16),
    .AXES(AXES),
    .STEP_PULSE_CLKS(SPC)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .abort(abort),
    .fifo_available(fifo_available), .fifo_request(fifo_request),
    .fifo_record_ready(fifo_record_ready), .fifo_record(fifo_record),
    .step(step), .dir(dir), .busy(busy), .segments_done(segments_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int axis;
    int cyc;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  mon_ev;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   exp_done = 0;
  int   acc_m[4];
  int   req_count = 0;
  int   rise_cyc[4];
  logic mon_en = 1'b1;
  logic [AXES-1:0] prev_step = '0;
  logic [AXES-1:0] prev_dir = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Pulse monitor: every rising step edge pops the next expected pulse.
  always @(negedge clk) begin
    if (fifo_request === 1'b1) req_count++;
    if (mon_en) begin
      for (int a = 0; a < AXES; a++) begin
        if (step[a] && !prev_step[a]) begin
          mon_ev.axis = -1;
          mon_ev.cyc  = -1;
          if (exp_q.size() > 0) mon_ev = exp_q.pop_front();
          check("pulse_axis", a, mon_ev.axis);
          check("pulse_start", cyc, mon_ev.cyc);
          rise_cyc[a] = cyc;
        end else if (!step[a] && prev_step[a]) begin
          check("pulse_width", cyc - rise_cyc[a], SPC);
        end
      end
      if (|prev_step) check("dir_stable", dir, prev_dir);
    end
    prev_step = step;
    prev_dir  = dir;
  end

  function automatic logic [127:0] mk_rec(input logic [31:0] loops, input logic [15:0] period,
                                          input logic [3:0] d, input logic [15:0] i0,
                                          input logic [15:0] i1, input logic [15:0] i2,
                                          input logic [15:0] i3);
    logic [127:0] r;
    r          = '0;
    r[127:96]  = loops;
    r[95:80]   = period;
    r[79:68]   = 12'hA5C;
    r[67:64]   = d;
    r[63:48]   = i3;
    r[47:32]   = i2;
    r[31:16]   = i1;
    r[15:0]    = i0;
    return r;
  endfunction

  // Reference DDA: ready seen in cycle r, tick k lands at r + eff*k, pulse one later.
  task automatic model_segment(input logic [127:0] rec, input int r);
    int unsigned loops_m;
    int eff;
    int s;
    ev_t e;
    loops_m = rec[127:96];
    eff     = int'(rec[95:80]);
    if (eff < 2 * SPC) eff = 2 * SPC;
    for (int k = 1; k <= int'(loops_m); k++) begin
      for (int a = 0; a < AXES; a++) begin
        s = acc_m[a] + int'(rec[16*a +: 16]);
        if (s > 65535) begin
          e.axis = a;
          e.cyc  = r + eff * k + 1;
          exp_q.push_back(e);
        end
        acc_m[a] = s & 65535;
      end
    end
    exp_done++;
  endtask

  task automatic wait_req(output int c);
    int n;
    n = 0;
    while (fifo_request !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("req_wait", fifo_request, 1);
    c = cyc;
  endtask

  task automatic serve(input logic [127:0] rec, input int lat, input logic more, output int r);
    repeat (lat) @(negedge clk);
    fifo_record       = rec;
    fifo_record_ready = 1'b1;
    if (!more) fifo_available = 1'b0;
    r = cyc;
    model_segment(rec, r);
    @(negedge clk);
    fifo_record_ready = 1'b0;
    fifo_record       = '0;
    check("dir_latch", dir, rec[67:64]);
  endtask

  task automatic wait_idle(output int c);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", busy, 0);
    check("seg_done", segments_done, exp_done);
    check("pulses_left", exp_q.size(), 0);
    c = cyc;
  endtask

  initial begin
    int r, c, req0, n;
    logic [127:0] rec;
    for (int a = 0; a < 4; a++) acc_m[a] = 0;
    rst = 1'b0; enable = 1'b0; abort = 1'b0; fifo_available = 1'b0;
    fifo_record_ready = 1'b0; fifo_record = '0;
    repeat (3) @(negedge clk);
    check("rst_request", fifo_request, 0);
    check("rst_step", step, 0);
    check("rst_dir", dir, 0);
    check("rst_busy", busy, 0);
    check("rst_done", segments_done, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Segment 1: loops=4 period=10 inc0=0x8000 dir=0001.
    enable = 1'b1; fifo_available = 1'b1;
    @(negedge clk);
    check("req_next_cycle", fifo_request, 1);
    @(negedge clk);
    check("req_one_cycle", fifo_request, 0);
    serve(mk_rec(32'd4, 16'd10, 4'b0001, 16'h8000, 16'h0, 16'h0, 16'h0), 0, 1'b0, r);
    check("busy_run", busy, 1);
    wait_idle(c);
    check("busy_fall", c, r + 46);

    // Segment 2: loops=3 period=8 inc1=0xFFFF, carries on ticks 2 and 3.
    fifo_available = 1'b1;
    wait_req(c);
    serve(mk_rec(32'd3, 16'd8, 4'b0010, 16'h0, 16'hFFFF, 16'h0, 16'h0), 3, 1'b0, r);
    wait_idle(c);

    // Clamped periods 0 and 3 back to back, consecutive pulses on axis 3.
    fifo_available = 1'b1;
    wait_req(c);
    serve(mk_rec(32'd3, 16'd0, 4'b1000, 16'h0, 16'h0, 16'h0, 16'hFFFF), 1, 1'b1, r);
    wait_req(c);
    serve(mk_rec(32'd3, 16'd3, 4'b1001, 16'h0, 16'h0, 16'h0, 16'hFFFF), 0, 1'b0, r);
    wait_idle(c);

    // loops=0 record is skipped and the next one fetched right away.
    fifo_available = 1'b1;
    wait_req(c);
    serve(mk_rec(32'd0, 16'd20, 4'b0110, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 0, 1'b1, r);
    check("skip_done", segments_done, exp_done);
    check("skip_idle", busy, 0);
    wait_req(c);
    check("skip_next_req", c, r + 2);
    serve(mk_rec(32'd2, 16'd8, 4'b0011, 16'h8000, 16'h0, 16'h0, 16'h0), 0, 1'b0, r);
    wait_idle(c);

    // Abort in FETCH, record arrives 5 cycles later and is dropped.
    req0 = req_count;
    fifo_available = 1'b1;
    wait_req(c);
    abort = 1'b1;
    fifo_available = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    check("discard_busy", busy, 1);
    repeat (4) @(negedge clk);
    fifo_record = mk_rec(32'd2, 16'd8, 4'b1100, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    fifo_record_ready = 1'b1;
    @(negedge clk);
    fifo_record_ready = 1'b0;
    fifo_record = '0;
    check("discard_idle", busy, 0);
    check("discard_dir", dir, 4'b0011);
    repeat (10) @(negedge clk);
    check("discard_step", step, 0);
    check("discard_done", segments_done, exp_done);
    check("discard_reqs", req_count - req0, 1);

    // Async reset in the middle of a pulse.
    mon_en = 1'b0;
    fifo_available = 1'b1;
    wait_req(c);
    serve(mk_rec(32'd3, 16'd8, 4'b0101, 16'hFFFF, 16'h0, 16'h0, 16'h0), 0, 1'b0, r);
    n = 0;
    while (step[0] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("pulse_before_reset", step[0], 1);
    #2 rst = 1'b0;
    #1;
    check("areset_step", step, 0);
    check("areset_dir", dir, 0);
    check("areset_busy", busy, 0);
    check("areset_done", segments_done, 0);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    for (int a = 0; a < 4; a++) acc_m[a] = 0;
    exp_done = 0;

    // enable low with records available: never a request.
    enable = 1'b0;
    fifo_available = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("no_req_disabled", {busy, fifo_request}, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
